// File: rtl/uart_cmd_pkg.sv
// uart_cmd_pkg
// Shared definitions for the UART command-frame controller:
//   - frame FSM state encoding (2 bits)
//   - default frame header byte and inter-byte timeout
//   - configuration register addresses
//   - checksum helper used to validate a frame
package uart_cmd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_VAL  = 2'd2,
    ST_CHK  = 2'd3
  } state_t;

  localparam logic [7:0] HEADER_DEF  = 8'hAA;
  localparam int         TIMEOUT_DEF = 100;

  // Configuration register addresses (pump, humidity threshold, period, mode)
  localparam logic [1:0] CFG_RIEGO   = 2'd0;
  localparam logic [1:0] CFG_UMBRAL  = 2'd1;
  localparam logic [1:0] CFG_PERIODO = 2'd2;
  localparam logic [1:0] CFG_MODO    = 2'd3;

  // Frame checksum: XOR of the command and value bytes
  function automatic logic [7:0] frame_chk(input logic [7:0] cmd, input logic [7:0] val);
    return cmd ^ val;
  endfunction

endpackage

// File: rtl/uart_byte_strobe.sv
// uart_byte_strobe
// Turns the UART receiver's "done" level into a one-cycle byte strobe and
// tracks the gap between bytes of a frame.
// Ports:
//   clk    in   system clock (same as receiver clkBaud)
//   rst    in   synchronous active-high reset
//   hecho  in   receiver done level; a 0->1 transition is one new byte
//   active in   frame in progress (FSM not idle); counter runs only then
//   stb    out  combinational byte strobe (hecho & ~hecho_q)
//   tmo    out  combinational timeout: counter at TIMEOUT-1 with no strobe
module uart_byte_strobe #(
  parameter int TIMEOUT = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic hecho,
  input  logic active,
  output logic stb,
  output logic tmo
);

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  logic        r_hecho_q;
  logic [15:0] r_cnt;
  logic        w_stb;

  // hecho_q resets high so a level already high at reset release is not a byte
  always_ff @(posedge clk) begin
    if (rst) r_hecho_q <= 1'b1;
    else     r_hecho_q <= hecho;
  end

  assign w_stb = hecho & ~r_hecho_q;

  always_ff @(posedge clk) begin
    if (rst)                   r_cnt <= '0;
    else if (w_stb || !active) r_cnt <= '0;
    else                       r_cnt <= r_cnt + 16'd1;
  end

  assign stb = w_stb;
  // A byte arriving in the timeout cycle takes precedence
  assign tmo = active & ~w_stb & (r_cnt == TMO_LAST);

endmodule

// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl
// Sequences the UART receiver byte stream into configuration writes.
// Frame: HEADER, cmd, val, chk where chk = cmd ^ val and cmd[7:2] == 0.
// A valid frame writes cfg[cmd[1:0]] = val and pulses ok; a bad checksum,
// bad command or inter-byte timeout pulses err and bumps err_cnt.
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   dato[7:0]       received byte, valid while hecho is high
//   hecho           receiver done level (rising edge = new byte)
//   cfg0..cfg3      configuration registers (pump, threshold, period, mode)
//   ok / err        one-cycle accept / reject pulses
//   err_cnt[7:0]    saturating rejected-frame count
//   busy            frame in progress
module uart_cmd_ctrl
  import uart_cmd_pkg::*;
#(
  parameter logic [7:0] HEADER  = HEADER_DEF,
  parameter int         TIMEOUT = TIMEOUT_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] dato,
  input  logic       hecho,
  output logic [7:0] cfg0,
  output logic [7:0] cfg1,
  output logic [7:0] cfg2,
  output logic [7:0] cfg3,
  output logic       ok,
  output logic       err,
  output logic [7:0] err_cnt,
  output logic       busy
);

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_t     r_state;
  logic [7:0] r_cmd;
  logic [7:0] r_val;
  logic [7:0] r_cfg [4];
  logic       r_ok;
  logic       r_err;
  logic [7:0] r_err_cnt;
  logic       r_busy;

  logic       w_stb;
  logic       w_tmo;
  logic       w_active;

  assign w_active = (r_state != ST_IDLE);

  uart_byte_strobe #(
    .TIMEOUT (TIMEOUT)
  ) u_strobe (
    .clk    (clk),
    .rst    (rst),
    .hecho  (hecho),
    .active (w_active),
    .stb    (w_stb),
    .tmo    (w_tmo)
  );

  // Command and value latches carry data only; no reset needed
  always_ff @(posedge clk) begin
    if (w_stb && r_state == ST_CMD) r_cmd <= dato;
    if (w_stb && r_state == ST_VAL) r_val <= dato;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state          <= ST_IDLE;
      r_cfg[CFG_RIEGO]   <= '0;
      r_cfg[CFG_UMBRAL]  <= '0;
      r_cfg[CFG_PERIODO] <= '0;
      r_cfg[CFG_MODO]    <= '0;
      r_ok             <= 1'b0;
      r_err            <= 1'b0;
      r_err_cnt        <= '0;
      r_busy           <= 1'b0;
    end else begin
      r_ok  <= 1'b0;
      r_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // Non-header bytes between frames are silently dropped
          if (w_stb && dato == HEADER) begin
            r_state <= ST_CMD;
            r_busy  <= 1'b1;
          end
        end
        ST_CMD: if (w_stb) r_state <= ST_VAL;
        ST_VAL: if (w_stb) r_state <= ST_CHK;
        ST_CHK: begin
          if (w_stb) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            if (dato == frame_chk(r_cmd, r_val) && r_cmd[7:2] == 6'd0) begin
              r_cfg[r_cmd[1:0]] <= r_val;
              r_ok              <= 1'b1;
            end else begin
              r_err     <= 1'b1;
              r_err_cnt <= sat_inc(r_err_cnt);
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
      // tmo is never asserted together with stb, so it cannot collide with
      // the checksum decision above
      if (w_tmo) begin
        r_state   <= ST_IDLE;
        r_busy    <= 1'b0;
        r_err     <= 1'b1;
        r_err_cnt <= sat_inc(r_err_cnt);
      end
    end
  end

  assign cfg0    = r_cfg[CFG_RIEGO];
  assign cfg1    = r_cfg[CFG_UMBRAL];
  assign cfg2    = r_cfg[CFG_PERIODO];
  assign cfg3    = r_cfg[CFG_MODO];
  assign ok      = r_ok;
  assign err     = r_err;
  assign err_cnt = r_err_cnt;
  assign busy    = r_busy;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Testbench for uart_cmd_ctrl: directed frames from the test plan with
// literal expectations, then randomized frames checked every cycle against
// a frame-level reference model.
module tb_uart_cmd_ctrl;

  localparam int         TMO = 100;
  localparam logic [7:0] HDR = 8'hAA;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       hecho = 1'b0;
  logic [7:0] dato = 8'h00;
  bit         byte_now = 1'b0;

  logic [7:0] cfg0, cfg1, cfg2, cfg3, err_cnt;
  logic       ok, err, busy;

  uart_cmd_ctrl #(
    .HEADER  (HDR),
    .TIMEOUT (TMO)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .dato    (dato),
    .hecho   (hecho),
    .cfg0    (cfg0),
    .cfg1    (cfg1),
    .cfg2    (cfg2),
    .cfg3    (cfg3),
    .ok      (ok),
    .err     (err),
    .err_cnt (err_cnt),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int ok_seen = 0;
  int err_seen = 0;

  // Reference model state: frame bytes collected since the header
  logic [7:0] m_cfg [4];
  logic       m_ok, m_err, m_busy;
  logic [7:0] m_ecnt;
  bit         in_frame = 1'b0;
  logic [7:0] fr [$];
  longint     cyc = 0;
  longint     last = 0;
  bit         primed = 1'b0;

  task automatic cmp8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %02h expected %02h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic cmp1(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic cmpi(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Compare DUT against the expectation for this cycle, then advance the
  // model with the inputs present during this cycle.
  always @(negedge clk) begin
    logic [7:0] c;
    if (primed) begin
      cmp8("cfg0", cfg0, m_cfg[0]);
      cmp8("cfg1", cfg1, m_cfg[1]);
      cmp8("cfg2", cfg2, m_cfg[2]);
      cmp8("cfg3", cfg3, m_cfg[3]);
      cmp8("err_cnt", err_cnt, m_ecnt);
      cmp1("ok", ok, m_ok);
      cmp1("err", err, m_err);
      cmp1("busy", busy, m_busy);
    end
    if (ok === 1'b1) ok_seen++;
    if (err === 1'b1) err_seen++;

    primed = 1'b1;
    m_ok   = 1'b0;
    m_err  = 1'b0;
    if (rst) begin
      for (int i = 0; i < 4; i++) m_cfg[i] = 8'h00;
      m_ecnt   = 8'h00;
      in_frame = 1'b0;
      fr.delete();
    end else if (byte_now) begin
      last = cyc;
      if (!in_frame) begin
        if (dato == HDR) begin
          in_frame = 1'b1;
          fr.delete();
        end
      end else begin
        fr.push_back(dato);
        if (fr.size() == 3) begin
          in_frame = 1'b0;
          c = fr[0];
          if (fr[2] == (fr[0] ^ fr[1]) && c < 8'd4) begin
            m_cfg[c[1:0]] = fr[1];
            m_ok = 1'b1;
          end else begin
            m_err = 1'b1;
            if (m_ecnt != 8'hFF) m_ecnt = m_ecnt + 8'd1;
          end
        end
      end
    end else if (in_frame && (cyc - last) == longint'(TMO)) begin
      in_frame = 1'b0;
      m_err = 1'b1;
      if (m_ecnt != 8'hFF) m_ecnt = m_ecnt + 8'd1;
    end
    m_busy = in_frame;
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One byte: hecho high for one cycle, then low for gap cycles
  task automatic send(input logic [7:0] b, input int gap);
    dato = b;
    hecho = 1'b1;
    byte_now = 1'b1;
    tick();
    hecho = 1'b0;
    byte_now = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [7:0] v, input logic [7:0] k,
                            input int g1, input int g2, input int g3, input int g4);
    send(HDR, g1);
    send(c, g2);
    send(v, g3);
    send(k, g4);
  endtask

  logic [7:0] rc, rv, rb;
  int         kind, nb, gpos, ok0, err0;

  initial begin
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    cmp1("reset_busy", busy, 1'b0);
    cmp8("reset_err_cnt", err_cnt, 8'h00);
    cmp8("reset_cfg0", cfg0, 8'h00);

    // Valid frame to period register
    ok0 = ok_seen;
    send_frame(8'h02, 8'h37, 8'h35, 2, 2, 2, 3);
    cmp8("t1_cfg2", cfg2, 8'h37);
    cmp8("t1_cfg0", cfg0, 8'h00);
    cmp8("t1_cfg3", cfg3, 8'h00);
    cmp8("t1_err_cnt", err_cnt, 8'h00);
    cmpi("t1_ok_pulses", ok_seen - ok0, 1);

    // Bad checksum
    err0 = err_seen;
    send_frame(8'h01, 8'h10, 8'h00, 2, 2, 2, 3);
    cmpi("t2_err_pulses", err_seen - err0, 1);
    cmp8("t2_err_cnt", err_cnt, 8'h01);
    cmp8("t2_cfg1", cfg1, 8'h00);
    cmp1("t2_busy", busy, 1'b0);

    // Correct checksum, illegal command
    send_frame(8'h05, 8'h10, 8'h15, 2, 2, 2, 3);
    cmp8("t3_err_cnt", err_cnt, 8'h02);
    cmp8("t3_cfg2", cfg2, 8'h37);

    // Leading junk ignored
    ok0 = ok_seen;
    send(8'h55, 2);
    send(8'h00, 2);
    send_frame(8'h00, 8'h20, 8'h20, 2, 2, 2, 3);
    cmp8("t4_cfg0", cfg0, 8'h20);
    cmp8("t4_err_cnt", err_cnt, 8'h02);
    cmpi("t4_ok_pulses", ok_seen - ok0, 1);

    // Timeout after two bytes, then recovery
    err0 = err_seen;
    send(HDR, 2);
    send(8'h03, TMO + 5);
    cmpi("t5_err_pulses", err_seen - err0, 1);
    cmp1("t5_busy", busy, 1'b0);
    cmp8("t5_err_cnt", err_cnt, 8'h03);
    send_frame(8'h03, 8'h01, 8'h02, 2, 2, 2, 3);
    cmp8("t5_cfg3", cfg3, 8'h01);

    // Reset mid-frame with hecho held high across release
    send(HDR, 2);
    send(8'h01, 2);
    rst = 1'b1;
    hecho = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    hecho = 1'b0;
    tick();
    cmp1("t6_busy", busy, 1'b0);
    cmp8("t6_cfg0", cfg0, 8'h00);
    cmp8("t6_cfg2", cfg2, 8'h00);
    cmp8("t6_cfg3", cfg3, 8'h00);
    cmp8("t6_err_cnt", err_cnt, 8'h00);
    ok0 = ok_seen;
    send_frame(8'h00, 8'h44, 8'h44, 2, 2, 2, 3);
    cmp8("t6_cfg0_after", cfg0, 8'h44);
    cmpi("t6_ok_pulses", ok_seen - ok0, 1);

    // Error counter saturation at minimum byte spacing
    err0 = err_seen;
    repeat (260) send_frame(8'h01, 8'h10, 8'h00, 1, 1, 1, 1);
    repeat (2) tick();
    cmp8("sat_err_cnt", err_cnt, 8'hFF);
    cmpi("sat_err_pulses", err_seen - err0, 260);

    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();

    // Randomized traffic
    repeat (400) begin
      kind = $urandom_range(0, 7);
      rc = 8'($urandom_range(0, 3));
      rv = 8'($urandom_range(0, 255));
      case (kind)
        0: begin
          rb = 8'($urandom_range(0, 255));
          if (rb == HDR) rb = 8'h00;
          send(rb, $urandom_range(1, 4));
        end
        1, 2, 3: send_frame(rc, rv, rc ^ rv, $urandom_range(1, 4), $urandom_range(1, 4),
                            $urandom_range(1, 4), $urandom_range(1, 4));
        4: begin
          rb = 8'($urandom_range(1, 255));
          send_frame(rc, rv, (rc ^ rv) ^ rb, $urandom_range(1, 4), $urandom_range(1, 4),
                     $urandom_range(1, 4), $urandom_range(1, 4));
        end
        5: begin
          rc = 8'($urandom_range(4, 255));
          send_frame(rc, rv, rc ^ rv, $urandom_range(1, 4), $urandom_range(1, 4),
                     $urandom_range(1, 4), $urandom_range(1, 4));
        end
        6: begin
          nb = $urandom_range(0, 2);
          if (nb == 0) send(HDR, TMO + $urandom_range(0, 3));
          else begin
            send(HDR, 2);
            if (nb == 2) send(rc, 2);
            send(rv, TMO + $urandom_range(0, 3));
          end
        end
        default: begin
          // A byte landing exactly on the timeout cycle must still count
          gpos = $urandom_range(1, 3);
          send_frame(rc, rv, rc ^ rv, (gpos == 1) ? TMO - 1 : 2, (gpos == 2) ? TMO - 1 : 2,
                     (gpos == 3) ? TMO - 1 : 2, 2);
        end
      endcase
    end

    repeat (TMO + 5) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_cmd_ctrl.md
# uart_cmd_ctrl

Command-frame controller that sits directly behind the UART receiver and sequences its byte stream into configuration writes for the plant controller. Each received byte (signalled by a rising edge of the receiver's `hecho` level) advances a frame FSM: header, command, value, checksum. Valid frames write one of four 8-bit configuration registers (pump, humidity threshold, sampling period, mode). Malformed or stalled frames are discarded and counted.

## Interface
- `HEADER`, 8'hAA: frame start byte.
- `TIMEOUT`, 100: maximum clk cycles between consecutive bytes of one frame; range 2..65535.
- `clk`  in  1  same clock as the UART receiver's `clkBaud`; all logic on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `dato`  in  8  received byte from the UART receiver; valid while `hecho`=1.
- `hecho`  in  1  receiver done level; a 0→1 transition marks one new byte.
- `cfg0`..`cfg3`  out  8 each  configuration registers (0 pump, 1 threshold, 2 period, 3 mode).
- `ok`  out  1  one-cycle pulse: frame accepted, cfg written.
- `err`  out  1  one-cycle pulse: frame rejected.
- `err_cnt`  out  8  saturating count of rejected frames.
- `busy`  out  1  high while the FSM is not in IDLE.

## Operation
- Byte strobe `stb` = `hecho` & ~`hecho_q`, with `hecho_q` a registered copy of `hecho`. Reset loads `hecho_q`=1, so a `hecho` already high when reset releases is not a byte.
- FSM states: IDLE, CMD, VAL, CHK.
  - IDLE: on `stb` with `dato`==HEADER → CMD. Other bytes are ignored, with no error.
  - CMD: on `stb` latch `cmd`=`dato` → VAL.
  - VAL: on `stb` latch `val`=`dato` → CHK.
  - CHK: on `stb`, compute `chk` = `cmd` ^ `val`, then → IDLE.
    - If `dato`==`chk` and `cmd[7:2]`==0: `cfg[cmd[1:0]]` <= `val`, pulse `ok`.
    - Otherwise pulse `err` and increment `err_cnt`.
- Timeout counter (16 bit):
  - Cleared on every `stb` and while in IDLE.
  - Increments each cycle in CMD/VAL/CHK.
  - When it reaches TIMEOUT-1 with no `stb` in that cycle: → IDLE, pulse `err`, increment `err_cnt`.
- Simultaneous `stb` and timeout in the same cycle: `stb` wins. The byte is processed and the counter clears.
- A HEADER byte received in CMD/VAL/CHK is treated as ordinary data. There is no resynchronisation mid-frame.
- `err_cnt` saturates at 255. Further errors still pulse `err`.
- `ok` and `err` are never high in the same cycle.
- Reset mid-frame: FSM → IDLE and the partial frame is dropped. `cfg` registers are also reset.

## Timing
- Reset values: `cfg0`..`cfg3`=0, `ok`=0, `err`=0, `err_cnt`=0, `busy`=0, FSM=IDLE, timeout counter=0, `hecho_q`=1.
- `stb` is combinational in the cycle where `hecho`=1 and `hecho_q`=0. The FSM acts on the clock edge that ends that cycle.
- Latency: `cfg` update and `ok` pulse are visible in the cycle after the checksum byte's `stb` cycle. Both are registered and change on the same edge.
- `err` on a timeout is visible in the cycle after the counter equals TIMEOUT-1.
- `busy` is registered from FSM state. It is high from the cycle after the header `stb` until the cycle after the closing `stb` or timeout.
- No back-pressure. One byte per `hecho` rising edge. Minimum byte spacing is 2 clk cycles.

## Structure
- Package `uart_cmd_pkg` holds:
  - FSM state encoding (2-bit: IDLE=0, CMD=1, VAL=2, CHK=3).
  - Default HEADER constant.
  - cfg address constants (CFG_RIEGO=0, CFG_UMBRAL=1, CFG_PERIODO=2, CFG_MODO=3).
- Sub-module `uart_byte_strobe`: `hecho` edge detector plus inter-byte timeout counter. Ports: `clk`, `rst`, `hecho`, `active`; outputs `stb`, `tmo`.
- The top level holds the FSM, the `cmd`/`val` latches, the cfg register file and the error counter.

## Test plan
- Frame AA 02 37 35 (35 = 02^37) → `ok` pulses once one cycle after the last `stb`; `cfg2`=8'h37; other cfgs stay 0; `err_cnt`=0.
- Frame AA 01 10 00 (bad checksum, expected 11) → `err` pulses once; `err_cnt`=1; `cfg1` stays 0; FSM returns to IDLE.
- Frame AA 05 10 15 (checksum correct, `cmd[7:2]`≠0) → `err` pulse; no cfg change; `err_cnt` increments.
- Bytes 55 00 AA 00 20 20 → the leading 55 and 00 are ignored; `ok` pulses; `cfg0`=8'h20.
- Timeout: AA, 03, then silence for 100 cycles → `err` pulses in the cycle after the counter hits 99; `busy`=0. A following AA 03 01 02 then sets `cfg3`=8'h01.
- Assert `rst` after AA 01 is received → all outputs return to reset values. Hold `hecho`=1 across reset release → no byte is seen; the next full frame is accepted normally.
